sdram_axi_tester: RTL and testbench

- AXI-style initiator that drives the SDRAM controller's single-beat slave port (AW/W/AR/R, no B channel) to run a write-then-read-back memory test.
- Writes TEST_WORDS addresses with a seeded pattern, reads each one back, compares, and reports pass/fail plus first-error capture.
- Used as the board-level self-test master on DE10-Lite and as the bus stimulus in controller regressions.

---
 rtl/sdram_axi_pkg.sv | 26 ++
 rtl/sdram_tester_watchdog.sv | 33 +++
 rtl/sdram_axi_tester.sv | 200 ++++++++++++++++++++
 tb/tb_sdram_axi_tester.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_axi_pkg.sv
`default_nettype none
// ============================================================================
// sdram_axi_pkg : shared state encodings, defaults and test pattern.
// Revision 1.0
// ============================================================================
package sdram_axi_pkg;

   localparam int DEF_ADDR_WIDTH     = 25;
   localparam int DEF_DATA_WIDTH     = 16;
   localparam int DEF_TIMEOUT_CYCLES = 65535;

   localparam int STATE_W = 3;
   localparam logic [STATE_W-1:0] ST_IDLE    = 3'd0;
   localparam logic [STATE_W-1:0] ST_WR_REQ  = 3'd1;
   localparam logic [STATE_W-1:0] ST_RD_REQ  = 3'd2;
   localparam logic [STATE_W-1:0] ST_RD_WAIT = 3'd3;
   localparam logic [STATE_W-1:0] ST_DONE    = 3'd4;

   // Callers truncate the result to their data width.
   function automatic logic [31:0] pattern_word(input logic [31:0] idx,
                                                input logic [31:0] seed);
      return idx ^ seed;
   endfunction

endpackage
`default_nettype wire

// File: rtl/sdram_tester_watchdog.sv
`default_nettype none
// ============================================================================
// sdram_tester_watchdog : per-handshake wait counter with expiry flag.
// Revision 1.0
// ============================================================================
module sdram_tester_watchdog #(
   parameter int LIMIT = 65535
) (
   input  logic clk,
   input  logic reset_n,
   input  logic load,
   input  logic count_en,
   output logic expired
);
   localparam int CNT_W = $clog2(LIMIT + 1);
   localparam logic [CNT_W-1:0] C_LAST = CNT_W'(LIMIT - 1);

   logic [CNT_W-1:0] r_count;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         r_count <= '0;
      else if (load)
         r_count <= '0;
      else if (count_en)
         r_count <= r_count + CNT_W'(1);
   end

   // Fires on the LIMIT-th consecutive waiting cycle.
   assign expired = count_en && !load && (r_count == C_LAST);

endmodule
`default_nettype wire

// File: rtl/sdram_axi_tester.sv
`default_nettype none
// ============================================================================
// sdram_axi_tester : write-then-read-back memory test master (AW/W/AR/R).
// Revision 1.0
// ============================================================================
module sdram_axi_tester
   import sdram_axi_pkg::*;
#(
   parameter int ADDR_WIDTH     = DEF_ADDR_WIDTH,
   parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
   parameter int TEST_WORDS     = 1024,
   parameter int ADDR_STRIDE    = 1,
   parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  start,
   input  logic [ADDR_WIDTH-1:0] base_addr,
   input  logic [DATA_WIDTH-1:0] seed,
   output logic                  busy,
   output logic                  done,
   output logic                  pass,
   output logic                  timeout,
   output logic [15:0]           err_count,
   output logic [ADDR_WIDTH-1:0] first_err_addr,
   output logic [DATA_WIDTH-1:0] first_err_rdata,
   output logic [ADDR_WIDTH-1:0] m_axi_awaddr,
   output logic                  m_axi_awvalid,
   input  logic                  m_axi_awready,
   output logic [DATA_WIDTH-1:0] m_axi_wdata,
   output logic                  m_axi_wvalid,
   input  logic                  m_axi_wready,
   output logic [ADDR_WIDTH-1:0] m_axi_araddr,
   output logic                  m_axi_arvalid,
   input  logic                  m_axi_arready,
   input  logic [DATA_WIDTH-1:0] m_axi_rdata,
   input  logic                  m_axi_rvalid,
   output logic                  m_axi_rready
);
   localparam int IDX_W = $clog2(TEST_WORDS + 1);
   localparam logic [IDX_W-1:0]      C_WORDS  = IDX_W'(TEST_WORDS);
   localparam logic [IDX_W-1:0]      C_LAST   = IDX_W'(TEST_WORDS - 1);
   localparam logic [ADDR_WIDTH-1:0] C_STRIDE = ADDR_WIDTH'(ADDR_STRIDE);

   logic [STATE_W-1:0]    r_state, w_next_state;
   logic                  r_gap;
   logic [IDX_W-1:0]      r_idx;
   logic [ADDR_WIDTH-1:0] r_addr, r_base;
   logic [DATA_WIDTH-1:0] r_seed, w_expect;
   logic                  r_done, r_pass, r_timeout;
   logic [15:0]           r_err_count;
   logic [ADDR_WIDTH-1:0] r_first_addr;
   logic [DATA_WIDTH-1:0] r_first_rdata;
   logic                  w_wr_hs, w_ar_hs, w_r_hs, w_expired;

   assign w_expect = DATA_WIDTH'(pattern_word(32'(r_idx), 32'(r_seed)));
   assign w_wr_hs  = m_axi_awvalid & m_axi_awready & m_axi_wvalid & m_axi_wready;
   assign w_ar_hs  = m_axi_arvalid & m_axi_arready;
   assign w_r_hs   = m_axi_rvalid & m_axi_rready;

   sdram_tester_watchdog #(
      .LIMIT    (TIMEOUT_CYCLES)
   ) u_watchdog (
      .clk      (clk),
      .reset_n  (reset_n),
      .load     (w_wr_hs | w_ar_hs | w_r_hs),
      .count_en (m_axi_awvalid | m_axi_arvalid | m_axi_rready),
      .expired  (w_expired)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         r_state <= ST_IDLE;
      else
         r_state <= w_next_state;
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         ST_IDLE:    if (start) w_next_state = ST_WR_REQ;
         ST_WR_REQ: begin
            if (r_gap) begin
               if (r_idx == C_WORDS) w_next_state = ST_RD_REQ;
            end else if (w_expired) begin
               w_next_state = ST_DONE;
            end
         end
         ST_RD_REQ: begin
            if (w_ar_hs)        w_next_state = ST_RD_WAIT;
            else if (w_expired) w_next_state = ST_DONE;
         end
         ST_RD_WAIT: begin
            if (w_r_hs)         w_next_state = (r_idx == C_LAST) ? ST_DONE : ST_RD_REQ;
            else if (w_expired) w_next_state = ST_DONE;
         end
         ST_DONE:    w_next_state = ST_IDLE;
         default:    w_next_state = ST_IDLE;
      endcase
   end

   // Valids derive from registered state only; r_gap forces the idle cycle between write beats.
   always_comb begin
      m_axi_awvalid = 1'b0;
      m_axi_wvalid  = 1'b0;
      m_axi_arvalid = 1'b0;
      m_axi_rready  = 1'b0;
      busy          = 1'b0;
      case (r_state)
         ST_WR_REQ: begin
            m_axi_awvalid = !r_gap;
            m_axi_wvalid  = !r_gap;
            busy          = 1'b1;
         end
         ST_RD_REQ: begin
            m_axi_arvalid = 1'b1;
            busy          = 1'b1;
         end
         ST_RD_WAIT: begin
            m_axi_rready = 1'b1;
            busy         = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_gap         <= 1'b0;
         r_idx         <= '0;
         r_addr        <= '0;
         r_base        <= '0;
         r_seed        <= '0;
         r_done        <= 1'b0;
         r_pass        <= 1'b0;
         r_timeout     <= 1'b0;
         r_err_count   <= '0;
         r_first_addr  <= '0;
         r_first_rdata <= '0;
      end else begin
         r_gap <= w_wr_hs;
         if (w_expired) r_timeout <= 1'b1;
         case (r_state)
            ST_IDLE: begin
               if (start) begin
                  r_done        <= 1'b0;
                  r_pass        <= 1'b0;
                  r_timeout     <= 1'b0;
                  r_err_count   <= '0;
                  r_first_addr  <= '0;
                  r_first_rdata <= '0;
                  r_base        <= base_addr;
                  r_seed        <= seed;
                  r_addr        <= base_addr;
                  r_idx         <= '0;
               end
            end
            ST_WR_REQ: begin
               if (w_wr_hs) begin
                  r_idx  <= r_idx + IDX_W'(1);
                  r_addr <= r_addr + C_STRIDE;
               end else if (r_gap && (r_idx == C_WORDS)) begin
                  r_idx  <= '0;
                  r_addr <= r_base;
               end
            end
            ST_RD_WAIT: begin
               if (w_r_hs) begin
                  if (m_axi_rdata != w_expect) begin
                     if (r_err_count == 16'd0) begin
                        r_first_addr  <= r_addr;
                        r_first_rdata <= m_axi_rdata;
                     end
                     if (r_err_count != 16'hFFFF) r_err_count <= r_err_count + 16'd1;
                  end
                  r_idx  <= r_idx + IDX_W'(1);
                  r_addr <= r_addr + C_STRIDE;
               end
            end
            ST_DONE: begin
               r_done <= 1'b1;
               r_pass <= (r_err_count == 16'd0) && !r_timeout;
            end
            default: ;
         endcase
      end
   end

   assign done            = r_done;
   assign pass            = r_pass;
   assign timeout         = r_timeout;
   assign err_count       = r_err_count;
   assign first_err_addr  = r_first_addr;
   assign first_err_rdata = r_first_rdata;
   assign m_axi_awaddr    = r_addr;
   assign m_axi_araddr    = r_addr;
   assign m_axi_wdata     = w_expect;

endmodule
`default_nettype wire

// File: tb/tb_sdram_axi_tester.sv
`default_nettype none
// ============================================================================
// tb_sdram_axi_tester : self-checking bench with behavioural AXI slave.
// Revision 1.0
// ============================================================================
module tb_sdram_axi_tester;
   localparam int AW    = 25;
   localparam int DW    = 16;
   localparam int WORDS = 4;
   localparam int TMO   = 50;

   logic          clk = 1'b0;
   logic          reset_n = 1'b1;
   logic          start = 1'b0;
   logic [AW-1:0] base_addr = '0;
   logic [DW-1:0] seed = '0;
   logic          busy, done, pass, timeout;
   logic [15:0]   err_count;
   logic [AW-1:0] first_err_addr, awaddr, araddr;
   logic [DW-1:0] first_err_rdata, wdata;
   logic          awvalid, wvalid, arvalid, rready;
   logic          awready = 1'b0, wready = 1'b0, arready = 1'b0, rvalid = 1'b0;
   logic [DW-1:0] rdata = '0;

   always #5 clk = ~clk;

   sdram_axi_tester #(
      .ADDR_WIDTH     (AW),
      .DATA_WIDTH     (DW),
      .TEST_WORDS     (WORDS),
      .ADDR_STRIDE    (1),
      .TIMEOUT_CYCLES (TMO)
   ) dut (
      .clk             (clk),
      .reset_n         (reset_n),
      .start           (start),
      .base_addr       (base_addr),
      .seed            (seed),
      .busy            (busy),
      .done            (done),
      .pass            (pass),
      .timeout         (timeout),
      .err_count       (err_count),
      .first_err_addr  (first_err_addr),
      .first_err_rdata (first_err_rdata),
      .m_axi_awaddr    (awaddr),
      .m_axi_awvalid   (awvalid),
      .m_axi_awready   (awready),
      .m_axi_wdata     (wdata),
      .m_axi_wvalid    (wvalid),
      .m_axi_wready    (wready),
      .m_axi_araddr    (araddr),
      .m_axi_arvalid   (arvalid),
      .m_axi_arready   (arready),
      .m_axi_rdata     (rdata),
      .m_axi_rvalid    (rvalid),
      .m_axi_rready    (rready)
   );

   int tests = 0;
   int fails = 0;

   // Slave: 0 = ideal, 1 = random readies/latency, 2 = AW and W ready in alternate cycles.
   int            slave_mode = 0;
   bit            corrupt_en = 1'b0;
   logic [AW-1:0] corrupt_addr = '0;
   logic [DW-1:0] mem [logic [AW-1:0]];
   typedef struct {
      logic [AW-1:0] a;
      logic [DW-1:0] d;
   } wr_t;
   wr_t           wr_log[$];
   wr_t           wr_e;
   int            proto_viol = 0;
   bit            pend = 1'b0, r_taken = 1'b0, wr_hs_last = 1'b0, split_phase = 1'b0;
   int            lat = 0;
   logic [AW-1:0] rd_addr = '0;

   always @(negedge clk) begin
      if (!reset_n) begin
         awready = 1'b0; wready = 1'b0; arready = 1'b0; rvalid = 1'b0; rdata = '0;
         pend = 1'b0; r_taken = 1'b0; wr_hs_last = 1'b0;
      end else begin
         if (wr_hs_last && (awvalid || wvalid)) proto_viol++;
         if (awvalid != wvalid) proto_viol++;
         if (awvalid && (arvalid || rready)) proto_viol++;
         if (r_taken) begin rvalid = 1'b0; r_taken = 1'b0; end
         case (slave_mode)
            0: begin awready = 1'b1; wready = 1'b1; arready = 1'b1; end
            1: begin
               awready = 1'($urandom_range(0, 1));
               wready  = 1'($urandom_range(0, 1));
               arready = 1'($urandom_range(0, 1));
            end
            default: begin
               split_phase = !split_phase;
               awready = split_phase; wready = !split_phase; arready = 1'b1;
            end
         endcase
         wr_hs_last = awvalid && wvalid && awready && wready;
         if (wr_hs_last) begin
            mem[awaddr] = wdata;
            wr_e.a = awaddr; wr_e.d = wdata;
            wr_log.push_back(wr_e);
         end
         if (pend && !rvalid) begin
            if (lat == 0) begin
               rvalid = 1'b1;
               if (corrupt_en && rd_addr == corrupt_addr) rdata = '0;
               else rdata = mem.exists(rd_addr) ? mem[rd_addr] : '0;
            end else lat--;
         end
         if (arvalid && arready && !pend) begin
            pend = 1'b1; rd_addr = araddr;
            lat = (slave_mode == 1) ? int'($urandom_range(0, 3)) : 0;
         end
         if (rvalid && rready) begin r_taken = 1'b1; pend = 1'b0; end
      end
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [AW-1:0] m_addr(input logic [AW-1:0] b, input int i);
      return b + AW'(i);
   endfunction

   function automatic logic [DW-1:0] m_data(input logic [DW-1:0] s, input int i);
      return DW'(i) ^ s;
   endfunction

   task automatic start_run(input logic [AW-1:0] b, input logic [DW-1:0] s);
      @(negedge clk);
      base_addr = b; seed = s; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_done(input string name, output bit ok);
      ok = 1'b0;
      for (int c = 0; c < 2000; c++) begin
         if (done) begin ok = 1'b1; break; end
         @(negedge clk);
      end
      if (!ok) begin
         tests++; fails++;
         $display("FAIL %s: done never rose, got 0 expected 1", name);
      end
   endtask

   task automatic verify(input string name, input logic [AW-1:0] b, input logic [DW-1:0] s,
                         input bit ep, input logic [15:0] ee,
                         input logic [AW-1:0] efa, input logic [DW-1:0] efr);
      bit ok;
      wait_done(name, ok);
      if (ok) begin
         check({name, " pass"},      64'(pass), 64'(ep));
         check({name, " err_count"}, 64'(err_count), 64'(ee));
         check({name, " first_err"}, 64'({first_err_addr, first_err_rdata}), 64'({efa, efr}));
         check({name, " status"},    64'({busy, timeout}), 64'(0));
         check({name, " writes"},    64'(wr_log.size()), 64'(WORDS));
         for (int i = 0; i < WORDS && i < wr_log.size(); i++)
            check($sformatf("%s write%0d", name, i), 64'({wr_log[i].a, wr_log[i].d}),
                  64'({m_addr(b, i), m_data(s, i)}));
      end
   endtask

   task automatic model(input logic [AW-1:0] b, input logic [DW-1:0] s, input bit cen,
                        input logic [AW-1:0] ca, output bit ep, output logic [15:0] ee,
                        output logic [AW-1:0] efa, output logic [DW-1:0] efr);
      logic [DW-1:0] rd;
      ee = 0; efa = '0; efr = '0;
      for (int i = 0; i < WORDS; i++) begin
         rd = (cen && m_addr(b, i) == ca) ? '0 : m_data(s, i);
         if (rd != m_data(s, i)) begin
            if (ee == 0) begin efa = m_addr(b, i); efr = rd; end
            ee++;
         end
      end
      ep = (ee == 0);
   endtask

   typedef struct {
      string         name;
      logic [AW-1:0] base;
      logic [DW-1:0] seed;
      bit            cen;
      logic [AW-1:0] caddr;
      int            mode;
      bit            exp_pass;
      logic [15:0]   exp_err;
      logic [AW-1:0] exp_fa;
      logic [DW-1:0] exp_fr;
   } vec_t;
   vec_t vecs[5];

   initial begin
      logic [AW-1:0] cap_a, rb, rca;
      logic [DW-1:0] cap_d, rs, efr;
      logic [AW-1:0] efa;
      logic [15:0]   ee;
      bit            ep, ok, rcen;
      int            viol;

      vecs[0] = '{"ideal",   25'h100,     16'hA5A5, 1'b0, 25'h0,   0, 1'b1, 16'd0, 25'h0,   16'h0};
      vecs[1] = '{"corrupt", 25'h100,     16'hA5A5, 1'b1, 25'h102, 0, 1'b0, 16'd1, 25'h102, 16'h0};
      vecs[2] = '{"wrap",    25'h1FFFFFE, 16'h1234, 1'b0, 25'h0,   0, 1'b1, 16'd0, 25'h0,   16'h0};
      vecs[3] = '{"zeroval", 25'h0,       16'h0000, 1'b1, 25'h0,   0, 1'b1, 16'd0, 25'h0,   16'h0};
      vecs[4] = '{"randslv", 25'h50,      16'hFFFF, 1'b1, 25'h53,  1, 1'b0, 16'd1, 25'h53,  16'h0};

      #2 reset_n = 1'b0;
      repeat (3) @(negedge clk);
      check("reset flags", 64'({busy, done, pass, timeout, awvalid, wvalid, arvalid, rready}), 64'(0));
      check("reset counters", 64'({err_count, first_err_addr, first_err_rdata}), 64'(0));
      check("reset buses", 64'({awaddr, araddr}), 64'(0));
      check("reset wdata", 64'(wdata), 64'(0));
      reset_n = 1'b1;

      for (int v = 0; v < 5; v++) begin
         slave_mode = vecs[v].mode; corrupt_en = vecs[v].cen; corrupt_addr = vecs[v].caddr;
         wr_log.delete();
         start_run(vecs[v].base, vecs[v].seed);
         check({vecs[v].name, " busy"}, 64'({busy, done}), 64'(2'b10));
         verify(vecs[v].name, vecs[v].base, vecs[v].seed, vecs[v].exp_pass,
                vecs[v].exp_err, vecs[v].exp_fa, vecs[v].exp_fr);
      end

      for (int r = 0; r < 6; r++) begin
         rb = AW'($urandom); rs = DW'($urandom);
         rcen = 1'($urandom_range(0, 1)); rca = rb + AW'($urandom_range(0, 5));
         model(rb, rs, rcen, rca, ep, ee, efa, efr);
         slave_mode = 1; corrupt_en = rcen; corrupt_addr = rca;
         wr_log.delete();
         start_run(rb, rs);
         verify($sformatf("rand%0d", r), rb, rs, ep, ee, efa, efr);
      end

      // AW and W never ready together: write must hold and then time out.
      slave_mode = 2; corrupt_en = 1'b0; wr_log.delete();
      start_run(25'h40, 16'h0F0F);
      cap_a = awaddr; cap_d = wdata;
      check("split first beat", 64'({awvalid, wvalid, cap_a, cap_d}), 64'({2'b11, 25'h40, 16'h0F0F}));
      viol = 0;
      repeat (40) begin
         @(negedge clk);
         if (!(awvalid && wvalid && awaddr == cap_a && wdata == cap_d)) viol++;
      end
      check("split stable", 64'(viol), 64'(0));
      wait_done("split", ok);
      if (ok) begin
         check("split timeout/pass", 64'({timeout, pass}), 64'(2'b10));
         check("split err_count", 64'(err_count), 64'(0));
         check("split no write", 64'(wr_log.size()), 64'(0));
      end

      // A second start while busy must not retarget the run.
      slave_mode = 0; wr_log.delete();
      start_run(25'h200, 16'h1111);
      repeat (3) @(negedge clk);
      base_addr = 25'h300; seed = 16'h2222; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      verify("busy start", 25'h200, 16'h1111, 1'b1, 16'd0, 25'h0, 16'h0);

      // Reset in the middle of the read phase.
      start_run(25'h600, 16'h3C3C);
      ok = 1'b0;
      for (int c = 0; c < 200; c++) begin
         if (rready) begin ok = 1'b1; break; end
         @(negedge clk);
      end
      check("reach read phase", 64'(ok), 64'(1));
      #1 reset_n = 1'b0;
      #1;
      check("midrun reset flags", 64'({busy, done, pass, timeout, awvalid, wvalid, arvalid, rready}), 64'(0));
      check("midrun reset counters", 64'({err_count, first_err_addr, first_err_rdata}), 64'(0));
      check("midrun reset buses", 64'({awaddr, araddr}), 64'(0));
      check("midrun reset wdata", 64'(wdata), 64'(0));
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      wr_log.delete();
      start_run(25'h600, 16'h3C3C);
      verify("after reset", 25'h600, 16'h3C3C, 1'b1, 16'd0, 25'h0, 16'h0);

      check("protocol violations", 64'(proto_viol), 64'(0));
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL global: simulation time limit reached, got running expected finished");
      $fatal(1, "time limit");
   end

endmodule
`default_nettype wire
